corr_sched: RTL and testbench
=============================

# corr_sched

Time-multiplexed scheduler that shares one offset/gain correction datapath among NCH sample channels in the acquisition path. It arbitrates among the channels' raw samples and holds per-channel offset/gain calibration registers. It drives the shared combinational datapath, captures the corrected byte and presents it downstream tagged with its channel number. It sits between the per-channel sample capture and the trace RAM write logic.

## Interface
- NCH, 3, number of requesting channels (2..4)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- smpl_vld  in  NCH  per-channel raw sample valid
- smpl_raw  in  8*NCH  raw samples, channel i at bits [8i+7:8i]
- smpl_rdy  out  NCH  one-hot accept strobe; sample consumed when vld&rdy
- cfg_we  in  1  calibration register write strobe
- cfg_ch  in  2  channel addressed by write (values >= NCH ignored)
- cfg_sel  in  1  0 = offset (signed), 1 = gain (unsigned, 0x80 = unity)
- cfg_data  in  8  write data
- corr_raw  out  8  raw value to shared datapath
- corr_offset  out  8  signed offset to shared datapath
- corr_gain  out  8  gain to shared datapath
- corr_out  in  8  corrected result from shared datapath (combinational)
- out_vld  out  1  corrected sample valid
- out_ch  out  2  channel of out_data
- out_data  out  8  corrected sample
- out_rdy  in  1  downstream accept

## Operation
- Calibration file: NCH offset regs (reset 0x00) and NCH gain regs (reset 0x80). A write takes effect on the following clock edge. Writes are accepted in any FSM state.
- FSM states: IDLE, DRIVE, OUT.
  - IDLE: if any smpl_vld, grant one channel. Assert smpl_rdy[g] combinationally that cycle. Latch raw, offset[g], gain[g] and g into operand regs. Next state DRIVE. If no smpl_vld, stay in IDLE.
  - DRIVE: corr_* outputs reflect the operand regs. Capture corr_out into out_data and g into out_ch at the end of the cycle. Set out_vld. Next state OUT.
  - OUT: hold out_vld/out_data/out_ch stable until out_rdy=1. On that cycle clear out_vld and go to IDLE. No grant is made in OUT.
- Arbitration: round-robin. Search starts at (last_grant+1) mod NCH. last_grant resets to NCH-1, so channel 0 wins the first contest. last_grant updates only on a grant.
- Operand regs drive corr_* continuously. They change only on a grant.
- Calibration is sampled at grant. A cfg write to the granted channel in the grant cycle does not affect that sample, only later grants.
- smpl_rdy is 0 in DRIVE and OUT. A channel's vld may stay high across cycles and is not dropped.

## Timing
- Reset values: smpl_rdy=0, out_vld=0, out_data=0x00, out_ch=0, corr_raw=0x00, corr_offset=0x00, corr_gain=0x80, state=IDLE, last_grant=NCH-1.
- Latency: grant in cycle N, out_vld high in cycle N+2.
- Peak throughput: one sample per 3 cycles with out_rdy tied high.
- Backpressure: out_rdy low holds the FSM in OUT indefinitely, with outputs unchanged.
- Reset mid-operation: an in-flight sample is discarded with no output. Calibration registers return to their reset values.
- Datapath contract: corr_out must be valid within one cycle of stable corr_* inputs. The datapath holds no internal state.

## Configuration
- CORR_SCHED_PRIO_EN defined: fixed priority, lowest-index valid channel always wins, and last_grant is unused.
- Not defined: round-robin as described above.

## Test plan
- Unity calibration, ch0 raw 0x40, out_rdy high -> out_vld two cycles after grant, out_ch=0, out_data=0x40.
- cfg ch1 offset 0x20, raw 0xF0 -> datapath saturates high, out_data=0xFF. Then cfg ch1 offset 0xE0 (-32), raw 0x10 -> out_data=0x00.
- All three smpl_vld held high -> grant order 0,1,2,0,1,2 with smpl_rdy one-hot. With CORR_SCHED_PRIO_EN the order is 0,0,0.
- out_rdy low for 5 cycles during OUT -> out_data/out_ch stable, smpl_rdy=0 throughout. Release -> IDLE next cycle, then the next grant.
- cfg write gain=0x40 to ch2 in the same cycle ch2 is granted with raw 0x80 -> that sample uses 0x80 gain and outputs 0x80. The next ch2 sample of 0x80 outputs 0x40.
- Assert rst_n low during DRIVE -> no out_vld. All outputs at reset values next cycle. Gain regs read back 0x80 (unity output on the next sample).

Source files
------------

// File: rtl/corr_sched_if.sv
// rtl/corr_sched_if.sv - sample, calibration, datapath and output bundle of corr_sched
interface corr_sched_if #(
    parameter int NCH = 3
);
    logic [NCH-1:0]   smpl_vld;
    logic [8*NCH-1:0] smpl_raw;
    logic [NCH-1:0]   smpl_rdy;

    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic             cfg_sel;
    logic [7:0]       cfg_data;

    logic [7:0]       corr_raw;
    logic [7:0]       corr_offset;
    logic [7:0]       corr_gain;
    logic [7:0]       corr_out;

    logic             out_vld;
    logic [1:0]       out_ch;
    logic [7:0]       out_data;
    logic             out_rdy;

    modport master (
        output smpl_vld, smpl_raw, cfg_we, cfg_ch, cfg_sel, cfg_data, corr_out, out_rdy,
        input  smpl_rdy, corr_raw, corr_offset, corr_gain, out_vld, out_ch, out_data
    );

    modport slave (
        input  smpl_vld, smpl_raw, cfg_we, cfg_ch, cfg_sel, cfg_data, corr_out, out_rdy,
        output smpl_rdy, corr_raw, corr_offset, corr_gain, out_vld, out_ch, out_data
    );
endinterface

// File: rtl/corr_sched.sv
// rtl/corr_sched.sv - shares one offset/gain correction datapath among NCH channels
// CORR_SCHED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module corr_sched #(
    parameter int NCH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    corr_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, OUT} state_t;

    state_t     state, state_d;
    logic [7:0] off_q  [NCH];
    logic [7:0] gain_q [NCH];
    logic [7:0] op_raw, op_off, op_gain;
    logic [1:0] op_ch;
    logic       out_vld_q;
    logic [1:0] out_ch_q;
    logic [7:0] out_data_q;

    logic [3:0] vld4;
    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       grant;
    logic       cfg_hit;

`ifndef CORR_SCHED_PRIO_EN
    logic [1:0] last_grant;
`endif

    assign vld4 = 4'(bus.smpl_vld);

    // First valid channel found walking the search order wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < NCH; k++) begin
`ifdef CORR_SCHED_PRIO_EN
            cand = 2'(k);
`else
            cand = 2'((int'(last_grant) + 1 + k) % NCH);
`endif
            if (!gnt_found && vld4[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign grant        = (state == IDLE) && gnt_found;
    assign bus.smpl_rdy = NCH'(grant) << gnt_idx;
    assign cfg_hit      = bus.cfg_we && (int'(bus.cfg_ch) < NCH);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (gnt_found) state_d = DRIVE;
            DRIVE:   state_d = OUT;
            OUT:     if (bus.out_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < NCH; i++) begin
                off_q[i]  <= 8'h00;
                gain_q[i] <= 8'h80;
            end
            op_raw     <= 8'h00;
            op_off     <= 8'h00;
            op_gain    <= 8'h80;
            op_ch      <= 2'd0;
            out_vld_q  <= 1'b0;
            out_ch_q   <= 2'd0;
            out_data_q <= 8'h00;
`ifndef CORR_SCHED_PRIO_EN
            last_grant <= 2'(NCH - 1);
`endif
        end else begin
            state <= state_d;
            if (cfg_hit) begin
                if (bus.cfg_sel) gain_q[bus.cfg_ch] <= bus.cfg_data;
                else             off_q[bus.cfg_ch]  <= bus.cfg_data;
            end
            // Calibration is read before this cycle's write lands, so a
            // same-cycle write only affects later grants.
            if (grant) begin
                op_raw  <= bus.smpl_raw[{gnt_idx, 3'b000} +: 8];
                op_off  <= off_q[gnt_idx];
                op_gain <= gain_q[gnt_idx];
                op_ch   <= gnt_idx;
`ifndef CORR_SCHED_PRIO_EN
                last_grant <= gnt_idx;
`endif
            end
            if (state == DRIVE) begin
                out_data_q <= bus.corr_out;
                out_ch_q   <= op_ch;
                out_vld_q  <= 1'b1;
            end else if (state == OUT && bus.out_rdy) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.corr_raw    = op_raw;
    assign bus.corr_offset = op_off;
    assign bus.corr_gain   = op_gain;
    assign bus.out_vld     = out_vld_q;
    assign bus.out_ch      = out_ch_q;
    assign bus.out_data    = out_data_q;
endmodule

// File: tb/tb_corr_sched.sv
// tb/tb_corr_sched.sv - directed and randomized checks of corr_sched against a transaction model
module tb_corr_sched;
    localparam int NCH = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    corr_sched_if #(.NCH(NCH)) bus ();
    corr_sched #(.NCH(NCH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [NCH-1:0] vld_b;
    logic [7:0]     raw_b [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_raw
        assign bus.smpl_raw[8*i +: 8] = raw_b[i];
    end
    assign bus.smpl_vld = vld_b;

    // Shared datapath: add signed offset, clamp, scale by gain/128, clamp.
    function automatic logic [7:0] dp(logic [7:0] r, logic [7:0] o, logic [7:0] g);
        int s;
        s = int'(r) + int'($signed(o));
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        s = (s * int'(g)) >>> 7;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    assign bus.corr_out = dp(bus.corr_raw, bus.corr_offset, bus.corr_gain);

    int total = 0;
    int bad   = 0;

    logic [7:0] m_off  [4];
    logic [7:0] m_gain [4];
    int         m_last;
    int         m_phase;
    int         p_ch;
    logic [7:0] p_raw, p_off, p_gain, p_val;
    int         last_w;
    int         grants[$];
    int         exp_ord[6];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_off[i]  = 8'h00;
            m_gain[i] = 8'h80;
        end
        m_last  = NCH - 1;
        m_phase = 0;
    endtask

    function automatic int pick(logic [NCH-1:0] v);
`ifdef CORR_SCHED_PRIO_EN
        for (int i = 0; i < NCH; i++)
            if (v[i]) return i;
`else
        for (int k = 0; k < NCH; k++)
            if (v[(m_last + 1 + k) % NCH]) return (m_last + 1 + k) % NCH;
`endif
        return -1;
    endfunction

    // One clock: check outputs against the model, take the edge, advance the model.
    task automatic step();
        int w;
        logic [NCH-1:0] exp_rdy;
        #1;
        w = (m_phase == 0) ? pick(vld_b) : -1;
        exp_rdy = (w >= 0) ? (NCH'(1) << w) : '0;
        if (rst_n) begin
            chk("smpl_rdy", 32'(bus.smpl_rdy), 32'(exp_rdy));
            chk("out_vld", 32'(bus.out_vld), 32'(m_phase == 2));
            if (m_phase == 2) begin
                chk("out_data", 32'(bus.out_data), 32'(p_val));
                chk("out_ch", 32'(bus.out_ch), 32'(p_ch));
            end
            if (m_phase == 1) begin
                chk("corr_raw", 32'(bus.corr_raw), 32'(p_raw));
                chk("corr_offset", 32'(bus.corr_offset), 32'(p_off));
                chk("corr_gain", 32'(bus.corr_gain), 32'(p_gain));
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            last_w = -1;
        end else begin
            last_w = w;
            if (w >= 0) begin
                p_ch    = w;
                p_raw   = raw_b[w];
                p_off   = m_off[w];
                p_gain  = m_gain[w];
                p_val   = dp(p_raw, p_off, p_gain);
                m_last  = w;
                m_phase = 1;
                grants.push_back(w);
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2 && bus.out_rdy) begin
                m_phase = 0;
            end
            if (bus.cfg_we && int'(bus.cfg_ch) < NCH) begin
                if (bus.cfg_sel) m_gain[bus.cfg_ch] = bus.cfg_data;
                else             m_off[bus.cfg_ch]  = bus.cfg_data;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_one(int ch, logic [7:0] raw, logic [7:0] exp, string tag);
        vld_b     = NCH'(1) << ch;
        raw_b[ch] = raw;
        step();
        vld_b = '0;
        step();
        chk({tag, "_vld"}, 32'(bus.out_vld), 32'd1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        chk({tag, "_ch"}, 32'(bus.out_ch), 32'(ch));
        step();
    endtask

    task automatic cfg_write(int ch, logic sel, logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'(ch);
        bus.cfg_sel  = sel;
        bus.cfg_data = data;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_rdy"}, 32'(bus.smpl_rdy), 32'd0);
        chk({tag, "_vld"}, 32'(bus.out_vld), 32'd0);
        chk({tag, "_data"}, 32'(bus.out_data), 32'h00);
        chk({tag, "_ch"}, 32'(bus.out_ch), 32'd0);
        chk({tag, "_raw"}, 32'(bus.corr_raw), 32'h00);
        chk({tag, "_off"}, 32'(bus.corr_offset), 32'h00);
        chk({tag, "_gain"}, 32'(bus.corr_gain), 32'h80);
    endtask

    initial begin
`ifdef CORR_SCHED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 0, 1, 2};
`endif
        rst_n        = 1'b0;
        vld_b        = '0;
        for (int i = 0; i < NCH; i++) raw_b[i] = 8'h00;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = 2'd0;
        bus.cfg_sel  = 1'b0;
        bus.cfg_data = 8'h00;
        bus.out_rdy  = 1'b1;
        model_reset();
        last_w = -1;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_reset_values("rst");

        run_one(0, 8'h40, 8'h40, "unity");

        cfg_write(1, 1'b0, 8'h20);
        run_one(1, 8'hF0, 8'hFF, "sat_hi");
        cfg_write(1, 1'b0, 8'hE0);
        run_one(1, 8'h10, 8'h00, "sat_lo");

        // Make ch2 the last grant so the all-valid contest starts at ch0.
        run_one(2, 8'h80, 8'h80, "rr_pre");
        grants.delete();
        vld_b = '1;
        for (int i = 0; i < NCH; i++) raw_b[i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 18; i++) step();
        vld_b = '0;
        for (int i = 0; i < 3; i++) step();
        chk("order_cnt", 32'(grants.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < grants.size()) chk("order", 32'(grants[i]), 32'(exp_ord[i]));

        bus.out_rdy = 1'b0;
        vld_b       = 3'b001;
        raw_b[0]    = 8'h5A;
        step();
        vld_b = 3'b110;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 32'(bus.out_vld), 32'd1);
            chk("bp_data", 32'(bus.out_data), 32'h5A);
            chk("bp_ch", 32'(bus.out_ch), 32'd0);
            step();
        end
        bus.out_rdy = 1'b1;
        step();
        grants.delete();
        step();
        vld_b = '0;
        chk("bp_next", 32'((grants.size() > 0) ? grants[0] : -1), 32'd1);
        for (int i = 0; i < 3; i++) step();

        vld_b    = 3'b100;
        raw_b[2] = 8'h80;
        cfg_write(2, 1'b1, 8'h40);
        vld_b = '0;
        step();
        chk("cg_same", 32'(bus.out_data), 32'h80);
        step();
        run_one(2, 8'h80, 8'h40, "cg_next");

        vld_b    = 3'b001;
        raw_b[0] = 8'h33;
        step();
        vld_b = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check_reset_values("mid_rst");
        step();
        step();
        run_one(2, 8'h80, 8'h80, "rst_gain");
        run_one(1, 8'h10, 8'h10, "rst_off");

        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom % 128) != 0;
            for (int i = 0; i < NCH; i++)
                if (!vld_b[i] && ($urandom % 3) == 0) begin
                    vld_b[i] = 1'b1;
                    raw_b[i] = 8'($urandom);
                end
            bus.cfg_we   = ($urandom % 4) == 0;
            bus.cfg_ch   = 2'($urandom);
            bus.cfg_sel  = 1'($urandom);
            bus.cfg_data = bus.cfg_sel ? 8'($urandom_range(32, 200)) : 8'($urandom);
            bus.out_rdy  = ($urandom % 3) != 0;
            step();
            if (last_w >= 0) vld_b[last_w] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
